// File: rtl/sram_pkg.sv
// Shared types and default geometry for the audio-buffer SRAM responder.
package sram_pkg;

  localparam int ADDR_W_DEF  = 20;
  localparam int RD_WAIT_DEF = 2;
  localparam int WR_WAIT_DEF = 2;
  localparam int DATA_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_WR_HOLD,
    S_DONE
  } state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_wr_forward.sv
// Single-entry store of the last completed write, with a lookup comparator
// so a read of that address can be answered without an SRAM cycle.
module sram_wr_forward
  import sram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              upd,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_data,
  input  logic [ADDR_W-1:0] look_addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic              valid;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (upd) begin
      valid  <= 1'b1;
      addr_q <= upd_addr;
      data_q <= upd_data;
    end
  end

  assign hit  = valid && (addr_q == look_addr);
  assign data = data_q;

endmodule

// File: rtl/sram_controller.sv
// Runs one asynchronous SRAM read or write per request pulse on a 1Mx16 part.
// Optional SRAM_WR_FORWARD_EN: reads of the last written address skip the SRAM.
module sram_controller
  import sram_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int RD_WAIT = RD_WAIT_DEF,
  parameter int WR_WAIT = WR_WAIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [31:0]       i_addr,
  inout  wire  [15:0]       io_data,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_SRAM_ADDR,
  inout  wire  [15:0]       io_SRAM_DQ,
  output logic              o_SRAM_CE_N,
  output logic              o_SRAM_OE_N,
  output logic              o_SRAM_WE_N,
  output logic              o_SRAM_UB_N,
  output logic              o_SRAM_LB_N
);

  localparam int CNT_W = $clog2(max2(RD_WAIT, WR_WAIT) + 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wr_data, rd_data;
  logic              is_rd;
  logic              rd_last, wr_last, req;
  logic              dq_oe, data_oe;
  logic              fwd_hit;
  logic [15:0]       fwd_data;

  assign req     = (state == S_IDLE) && (i_read || i_write);
  assign rd_last = (state == S_RD) && (cnt == CNT_W'(RD_WAIT - 1));
  assign wr_last = (state == S_WR) && (cnt == CNT_W'(WR_WAIT - 1));

`ifdef SRAM_WR_FORWARD_EN
  sram_wr_forward #(.ADDR_W(ADDR_W)) u_fwd (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .upd       (state == S_WR_HOLD),
    .upd_addr  (addr_q),
    .upd_data  (wr_data),
    .look_addr (i_addr[ADDR_W-1:0]),
    .hit       (fwd_hit),
    .data      (fwd_data)
  );
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        // read wins over a simultaneous write
        if (i_read)       state_nx = fwd_hit ? S_DONE : S_RD;
        else if (i_write) state_nx = S_WR;
      end
      S_RD:      if (rd_last) state_nx = S_DONE;
      S_WR:      if (wr_last) state_nx = S_WR_HOLD;
      S_WR_HOLD: state_nx = S_DONE;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  always_comb begin
    o_SRAM_CE_N = 1'b1;
    o_SRAM_OE_N = 1'b1;
    o_SRAM_WE_N = 1'b1;
    o_SRAM_UB_N = 1'b1;
    o_SRAM_LB_N = 1'b1;
    o_done      = 1'b0;
    dq_oe       = 1'b0;
    data_oe     = 1'b0;
    case (state)
      S_RD: begin
        o_SRAM_CE_N = 1'b0;
        o_SRAM_OE_N = 1'b0;
        o_SRAM_UB_N = 1'b0;
        o_SRAM_LB_N = 1'b0;
      end
      S_WR: begin
        o_SRAM_CE_N = 1'b0;
        o_SRAM_WE_N = 1'b0;
        o_SRAM_UB_N = 1'b0;
        o_SRAM_LB_N = 1'b0;
        dq_oe       = 1'b1;
      end
      S_WR_HOLD: begin
        o_SRAM_CE_N = 1'b0;
        o_SRAM_UB_N = 1'b0;
        o_SRAM_LB_N = 1'b0;
        dq_oe       = 1'b1;
      end
      S_DONE: begin
        o_done  = 1'b1;
        data_oe = is_rd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      addr_q  <= '0;
      wr_data <= '0;
      rd_data <= '0;
      is_rd   <= 1'b0;
    end else begin
      if (req) begin
        cnt    <= '0;
        addr_q <= i_addr[ADDR_W-1:0];
        is_rd  <= i_read;
        if (!i_read)       wr_data <= io_data;
        if (i_read && fwd_hit) rd_data <= fwd_data;
      end else if (state == S_RD || state == S_WR) begin
        cnt <= cnt + 1'b1;
      end
      if (rd_last) rd_data <= io_SRAM_DQ;
    end
  end

  assign o_SRAM_ADDR = addr_q;
  assign io_SRAM_DQ  = dq_oe   ? wr_data : 'z;
  assign io_data     = data_oe ? rd_data : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a small SRAM model on the pad side.
module tb_sram_controller;

`ifdef SRAM_WR_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic        i_clk, i_rst, i_read, i_write;
  logic [31:0] i_addr;
  wire  [15:0] io_data;
  wire  [15:0] io_SRAM_DQ;
  logic        o_done;
  logic [19:0] o_SRAM_ADDR;
  logic        o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N;

  logic        tb_en;
  logic [15:0] tb_val;
  logic        dq_probe;
  logic [15:0] mem [0:255];
  int          total, bad;

  sram_controller dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_read      (i_read),
    .i_write     (i_write),
    .i_addr      (i_addr),
    .io_data     (io_data),
    .o_done      (o_done),
    .o_SRAM_ADDR (o_SRAM_ADDR),
    .io_SRAM_DQ  (io_SRAM_DQ),
    .o_SRAM_CE_N (o_SRAM_CE_N),
    .o_SRAM_OE_N (o_SRAM_OE_N),
    .o_SRAM_WE_N (o_SRAM_WE_N),
    .o_SRAM_UB_N (o_SRAM_UB_N),
    .o_SRAM_LB_N (o_SRAM_LB_N)
  );

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end

  // SRAM model, preloaded with 0x1000+index while reset is high.
  always @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'h1000 + 16'(k);
    end else if (!o_SRAM_CE_N && !o_SRAM_WE_N) begin
      mem[o_SRAM_ADDR[7:0]] <= io_SRAM_DQ;
    end
  end

  assign io_SRAM_DQ = (!o_SRAM_CE_N && !o_SRAM_OE_N) ? mem[o_SRAM_ADDR[7:0]] :
                      dq_probe ? 16'hC3C3 : 'z;
  assign io_data    = tb_en ? tb_val : 'z;

  task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [15:0] data, output int lat, output logic [15:0] rdat,
                        output int we_lo, output int oe_lo, output logic [19:0] a1);
    @(negedge i_clk);
    i_read = rd; i_write = wr; i_addr = addr; tb_en = wr; tb_val = data;
    @(posedge i_clk);
    @(negedge i_clk);
    i_read = 0; i_write = 0;
    // during a write completion the bench probes io_data to see it is undriven
    tb_en = wr & ~rd; tb_val = 16'hC3C3;
    lat = 0; we_lo = 0; oe_lo = 0; rdat = 16'h0; a1 = o_SRAM_ADDR;
    for (int c = 1; c <= 20; c++) begin
      if (!o_SRAM_WE_N) we_lo++;
      if (!o_SRAM_OE_N) oe_lo++;
      if (o_done) begin
        lat = c; rdat = io_data;
        break;
      end
      @(negedge i_clk);
    end
    tb_en = 0;
  endtask

  task automatic test_reset;
    i_rst = 1; i_read = 0; i_write = 0; i_addr = 0; tb_en = 0; tb_val = 0; dq_probe = 0;
    repeat (2) @(negedge i_clk);
    total++;
    if ({o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N, o_done} !== 6'b111110) begin
      bad++; $display("FAIL reset_strobes got=%b want=111110",
        {o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N, o_done});
    end
    total++;
    if (o_SRAM_ADDR !== 20'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", o_SRAM_ADDR); end
    i_rst = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge i_clk);
      total++;
      if ({o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N, o_done} !== 6'b111110) begin
        bad++; $display("FAIL idle_strobes cyc=%0d got=%b want=111110", c,
          {o_SRAM_CE_N, o_SRAM_OE_N, o_SRAM_WE_N, o_SRAM_UB_N, o_SRAM_LB_N, o_done});
      end
    end
  endtask

  task automatic test_write_read;
    int lat, we_lo, oe_lo;
    logic [15:0] rdat;
    logic [19:0] a1;
    do_req(0, 1, 32'h10, 16'h1234, lat, rdat, we_lo, oe_lo, a1);
    total++; if (lat !== 4) begin bad++; $display("FAIL wr_latency got=%0d want=4", lat); end
    total++; if (we_lo !== 2) begin bad++; $display("FAIL wr_we_low got=%0d want=2", we_lo); end
    total++; if (rdat !== 16'hC3C3) begin bad++; $display("FAIL wr_done_bus got=%h want=c3c3", rdat); end
    total++; if (a1 !== 20'h10) begin bad++; $display("FAIL wr_addr got=%h want=00010", a1); end
    total++; if (mem[8'h10] !== 16'h1234) begin bad++; $display("FAIL wr_mem got=%h want=1234", mem[8'h10]); end
    do_req(1, 0, 32'h10, 16'h0, lat, rdat, we_lo, oe_lo, a1);
    total++; if (lat !== (FWD ? 1 : 3)) begin bad++; $display("FAIL rd_latency got=%0d want=%0d", lat, FWD ? 1 : 3); end
    total++; if (oe_lo !== (FWD ? 0 : 2)) begin bad++; $display("FAIL rd_oe_low got=%0d want=%0d", oe_lo, FWD ? 0 : 2); end
    total++; if (rdat !== 16'h1234) begin bad++; $display("FAIL rd_data got=%h want=1234", rdat); end
  endtask

  task automatic test_bus_idle;
    // DUT registers now hold 0x1234; any stray drive would corrupt the probe value
    @(negedge i_clk);
    tb_en = 1; tb_val = 16'hC3C3; dq_probe = 1;
    @(negedge i_clk);
    total++; if (io_data !== 16'hC3C3) begin bad++; $display("FAIL idle_io_data got=%h want=c3c3", io_data); end
    total++; if (io_SRAM_DQ !== 16'hC3C3) begin bad++; $display("FAIL idle_sram_dq got=%h want=c3c3", io_SRAM_DQ); end
    tb_en = 0; dq_probe = 0;
  endtask

  task automatic test_addr_trunc;
    int lat, we_lo, oe_lo;
    logic [15:0] rdat;
    logic [19:0] a1;
    do_req(1, 0, 32'hFFF00005, 16'h0, lat, rdat, we_lo, oe_lo, a1);
    total++; if (a1 !== 20'h00005) begin bad++; $display("FAIL trunc_addr got=%h want=00005", a1); end
    total++; if (rdat !== 16'h1005) begin bad++; $display("FAIL trunc_data got=%h want=1005", rdat); end
    total++; if (o_SRAM_ADDR !== 20'h00005) begin bad++; $display("FAIL trunc_hold got=%h want=00005", o_SRAM_ADDR); end
  endtask

  task automatic test_dual_req;
    int lat, we_lo, oe_lo;
    logic [15:0] rdat;
    logic [19:0] a1;
    do_req(1, 1, 32'h20, 16'hAAAA, lat, rdat, we_lo, oe_lo, a1);
    total++; if (we_lo !== 0) begin bad++; $display("FAIL dual_we_low got=%0d want=0", we_lo); end
    total++; if (lat !== 3) begin bad++; $display("FAIL dual_latency got=%0d want=3", lat); end
    total++; if (rdat !== 16'h1020) begin bad++; $display("FAIL dual_data got=%h want=1020", rdat); end
    total++; if (mem[8'h20] !== 16'h1020) begin bad++; $display("FAIL dual_mem got=%h want=1020", mem[8'h20]); end
  endtask

  task automatic test_forward;
    int lat, we_lo, oe_lo;
    logic [15:0] rdat;
    logic [19:0] a1;
    do_req(0, 1, 32'h40, 16'hBEEF, lat, rdat, we_lo, oe_lo, a1);
    total++; if (lat !== 4) begin bad++; $display("FAIL fwd_wr_latency got=%0d want=4", lat); end
    do_req(1, 0, 32'h40, 16'h0, lat, rdat, we_lo, oe_lo, a1);
    total++; if (lat !== 1) begin bad++; $display("FAIL fwd_hit_latency got=%0d want=1", lat); end
    total++; if (oe_lo !== 0) begin bad++; $display("FAIL fwd_hit_oe got=%0d want=0", oe_lo); end
    total++; if (rdat !== 16'hBEEF) begin bad++; $display("FAIL fwd_hit_data got=%h want=beef", rdat); end
    do_req(1, 0, 32'h41, 16'h0, lat, rdat, we_lo, oe_lo, a1);
    total++; if (lat !== 3) begin bad++; $display("FAIL fwd_miss_latency got=%0d want=3", lat); end
    total++; if (oe_lo !== 2) begin bad++; $display("FAIL fwd_miss_oe got=%0d want=2", oe_lo); end
    total++; if (rdat !== 16'h1041) begin bad++; $display("FAIL fwd_miss_data got=%h want=1041", rdat); end
  endtask

  task automatic test_reset_mid;
    @(negedge i_clk);
    i_write = 1; i_addr = 32'h30; tb_en = 1; tb_val = 16'h7777;
    @(posedge i_clk);
    @(negedge i_clk);
    i_write = 0; tb_en = 0;
    total++; if (o_SRAM_WE_N !== 1'b0) begin bad++; $display("FAIL mid_we_active got=%b want=0", o_SRAM_WE_N); end
    #2 i_rst = 1;
    #1;
    total++;
    if ({o_SRAM_WE_N, o_SRAM_CE_N} !== 2'b11) begin
      bad++; $display("FAIL mid_async_strobes got=%b want=11", {o_SRAM_WE_N, o_SRAM_CE_N});
    end
    repeat (2) begin
      @(negedge i_clk);
      total++; if (o_done !== 1'b0) begin bad++; $display("FAIL mid_done_in_reset got=%b want=0", o_done); end
    end
    i_rst = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      total++;
      if ({o_SRAM_CE_N, o_SRAM_WE_N, o_done} !== 3'b110) begin
        bad++; $display("FAIL mid_after got=%b want=110", {o_SRAM_CE_N, o_SRAM_WE_N, o_done});
      end
    end
  endtask

  task automatic test_fwd_cleared;
    int lat, we_lo, oe_lo;
    logic [15:0] rdat;
    logic [19:0] a1;
    // reset cleared the forward entry and the model reloaded 0x1040
    do_req(1, 0, 32'h40, 16'h0, lat, rdat, we_lo, oe_lo, a1);
    total++; if (lat !== 3) begin bad++; $display("FAIL fwd_clr_latency got=%0d want=3", lat); end
    total++; if (rdat !== 16'h1040) begin bad++; $display("FAIL fwd_clr_data got=%h want=1040", rdat); end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset;
    test_write_read;
    test_bus_idle;
    test_addr_trunc;
    test_dual_req;
`ifdef SRAM_WR_FORWARD_EN
    test_forward;
`endif
    test_reset_mid;
`ifdef SRAM_WR_FORWARD_EN
    test_fwd_cleared;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
